// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and port identifiers for the register-file write-back arbiter
package wb_pkg;
  localparam int REG_CODE_W = 3;
  localparam int NUM_REGS = 8;
  typedef enum logic {WB_PORT_ALU = 1'b0, WB_PORT_MEM = 1'b1} wb_port_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of DEPTH entries with push/pop/flush and full/empty flags
//   clk, rst (sync, active-high), flush (sync clear), push/din write side,
//   pop/dout read side (dout shows the head while !empty), full, empty.
module wb_fifo #(
  parameter int W = 35,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign dout = mem[rp];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: buffers ALU/MEM write-backs and issues one round-robin register write per cycle
//   clk, rst (sync, active-high), flush_i (drops all pending writes),
//   p0_* ALU request port, p1_* MEM request port (valid/ready handshake, 3-bit dest, data),
//   wb_we_o/wb_code_o/wb_data_o registered write to the 3-to-8 decoder, busy_o,
//   stall_cnt_o arbitration-loss counter present only when WB_STALL_CNT_EN is defined.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 2,
  parameter int DROP_R0 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  p0_valid_i,
  output logic                  p0_ready_o,
  input  logic [REG_CODE_W-1:0] p0_dest_i,
  input  logic [DATA_W-1:0]     p0_data_i,
  input  logic                  p1_valid_i,
  output logic                  p1_ready_o,
  input  logic [REG_CODE_W-1:0] p1_dest_i,
  input  logic [DATA_W-1:0]     p1_data_i,
  output logic                  wb_we_o,
  output logic [REG_CODE_W-1:0] wb_code_o,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic                  busy_o
`ifdef WB_STALL_CNT_EN
  ,output logic [15:0]          stall_cnt_o
`endif
);
  localparam int W = DATA_W + REG_CODE_W;
  logic [W-1:0] h0, h1, ghead;
  logic full0, full1, empty0, empty1, g0, g1, gnt, drop;
  wb_port_e rr, gsel;
  assign p0_ready_o = !full0 && !flush_i && !rst;
  assign p1_ready_o = !full1 && !flush_i && !rst;
  wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .flush(flush_i),
    .push(p0_valid_i && p0_ready_o), .pop(g0),
    .din({p0_dest_i, p0_data_i}), .dout(h0), .full(full0), .empty(empty0)
  );
  wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .flush(flush_i),
    .push(p1_valid_i && p1_ready_o), .pop(g1),
    .din({p1_dest_i, p1_data_i}), .dout(h1), .full(full1), .empty(empty1)
  );
  always_comb begin
    g0 = !empty0 && (empty1 || rr == WB_PORT_ALU);
    g1 = !empty1 && (empty0 || rr == WB_PORT_MEM);
    gnt = g0 || g1;
    gsel = g1 ? WB_PORT_MEM : WB_PORT_ALU;
    ghead = g1 ? h1 : h0;
    // register 0 is hard-wired zero: consume the entry but never strobe it
    drop = DROP_R0 != 0 && ghead[DATA_W +: REG_CODE_W] == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= WB_PORT_ALU;
      wb_we_o <= 1'b0;
      wb_code_o <= '0;
      wb_data_o <= '0;
    end else if (flush_i) begin
      rr <= WB_PORT_ALU;
      wb_we_o <= 1'b0;
    end else begin
      if (gnt) rr <= gsel == WB_PORT_ALU ? WB_PORT_MEM : WB_PORT_ALU;
      wb_we_o <= gnt && !drop;
      if (gnt && !drop) {wb_code_o, wb_data_o} <= ghead;
    end
  end
  assign busy_o = !empty0 || !empty1 || wb_we_o;
`ifdef WB_STALL_CNT_EN
  // a loss happens only when both heads compete; flush cycles arbitrate nothing
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_o <= '0;
    else if (!empty0 && !empty1 && !flush_i && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif
endmodule
